// File: rtl/rf_bank_pkg.sv
// rtl/rf_bank_pkg.sv - shared types and helpers for the rf_bank register file
//
// Purpose: response encoding, byte-strobe expansion and address classification
//          used by rf_bank and its response slots.
package rf_bank_pkg;

   typedef enum logic {
      RESP_OK  = 1'b0,
      RESP_ERR = 1'b1
   } resp_t;

   // Widest strobe the helper supports; callers zero-extend their strobe to
   // this width and truncate the returned mask to their data width.
   localparam int unsigned STRB_MAX = 64;

   function automatic logic [STRB_MAX*8-1:0] strb_mask(input logic [STRB_MAX-1:0] strb);
      logic [STRB_MAX*8-1:0] m;
      for (int i = 0; i < STRB_MAX; i++) begin
         m[i*8 +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

   function automatic logic addr_is_ctrl(input logic [31:0] addr,
                                         input int unsigned num_ctrl);
      return addr < num_ctrl;
   endfunction

   function automatic logic addr_is_status(input logic [31:0] addr,
                                           input int unsigned num_ctrl,
                                           input int unsigned num_status);
      return (addr >= num_ctrl) && (addr < num_ctrl + num_status);
   endfunction

endpackage

// File: rtl/rf_resp_slot.sv
// rtl/rf_resp_slot.sv - one-entry valid/ready response register
//
// Purpose: holds one response payload; accepts a new one whenever the slot is
//          empty or is being drained in the same cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_tvalid/s_tready   upstream handshake, s_tdata payload in
//   m_tvalid/m_tready   downstream handshake, m_tdata payload out
module rf_resp_slot #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_tvalid,
   output logic         s_tready,
   input  logic [W-1:0] s_tdata,
   output logic         m_tvalid,
   input  logic         m_tready,
   output logic [W-1:0] m_tdata
);

   assign s_tready = !m_tvalid || m_tready;

   // Payload only moves on acceptance, so it stays stable under stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
      end else if (s_tvalid && s_tready) begin
         m_tvalid <= 1'b1;
         m_tdata  <= s_tdata;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_bank.sv
// rtl/rf_bank.sv - control/status register bank with valid/ready write and read channels
//
// Purpose: software-written control registers plus sticky hardware-set status
//          registers, registered responses on independent B and R channels.
// Optional feature: RF_BANK_W1C_EN makes status registers write-1-to-clear;
//          without it status writes are rejected with an error response.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wvalid/wready, waddr/wdata/wstrb   write request
//   bvalid/bready, bresp           write response
//   arvalid/aready, raddr          read request
//   rvalid/rready, rdata/rresp     read response
//   ctrl_o                         flattened control registers
//   hw_set_i                       flattened per-bit status set pulses
module rf_bank
   import rf_bank_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 4,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           NUM_CTRL   = 8,
   parameter int unsigned           NUM_STATUS = 4,
   parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wvalid,
   output logic                             wready,
   input  logic [ADDR_WIDTH-1:0]            waddr,
   input  logic [DATA_WIDTH-1:0]            wdata,
   input  logic [DATA_WIDTH/8-1:0]          wstrb,
   output logic                             bvalid,
   input  logic                             bready,
   output logic                             bresp,
   input  logic                             arvalid,
   output logic                             aready,
   input  logic [ADDR_WIDTH-1:0]            raddr,
   output logic                             rvalid,
   input  logic                             rready,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic                             rresp,
   output logic [NUM_CTRL*DATA_WIDTH-1:0]   ctrl_o,
   input  logic [NUM_STATUS*DATA_WIDTH-1:0] hw_set_i
);

   logic [DATA_WIDTH-1:0] ctrl_q     [NUM_CTRL];
   logic [DATA_WIDTH-1:0] status_q   [NUM_STATUS];
   logic [DATA_WIDTH-1:0] status_clr [NUM_STATUS];
   logic [DATA_WIDTH-1:0] wmask;
   logic                  w_accept;
   resp_t                 b_resp_d;
   resp_t                 r_resp_d;
   logic [DATA_WIDTH-1:0] r_data_d;
   logic [DATA_WIDTH:0]   r_payload;

   assign w_accept = wvalid && wready;
   assign wmask    = DATA_WIDTH'(strb_mask(STRB_MAX'(wstrb)));

   // Write response is decided purely from the address region.
   always_comb begin
      b_resp_d = RESP_ERR;
      if (addr_is_ctrl(32'(waddr), NUM_CTRL)) begin
         b_resp_d = RESP_OK;
      end
`ifdef RF_BANK_W1C_EN
      else if (addr_is_status(32'(waddr), NUM_CTRL, NUM_STATUS)) begin
         b_resp_d = RESP_OK;
      end
`endif
   end

   // Software clear mask per status register; stays zero when status is read-only.
   always_comb begin
      for (int j = 0; j < NUM_STATUS; j++) begin
         status_clr[j] = '0;
`ifdef RF_BANK_W1C_EN
         if (w_accept && waddr == ADDR_WIDTH'(NUM_CTRL + j)) begin
            status_clr[j] = wdata & wmask;
         end
`endif
      end
   end

   // Read mux sees register contents before this cycle's write commits.
   always_comb begin
      r_data_d = '0;
      r_resp_d = RESP_ERR;
      if (addr_is_ctrl(32'(raddr), NUM_CTRL) ||
          addr_is_status(32'(raddr), NUM_CTRL, NUM_STATUS)) begin
         r_resp_d = RESP_OK;
      end
      for (int i = 0; i < NUM_CTRL; i++) begin
         if (raddr == ADDR_WIDTH'(i)) begin
            r_data_d = ctrl_q[i];
         end
      end
      for (int j = 0; j < NUM_STATUS; j++) begin
         if (raddr == ADDR_WIDTH'(NUM_CTRL + j)) begin
            r_data_d = status_q[j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CTRL; i++) begin
            ctrl_q[i] <= CTRL_RESET;
         end
         for (int j = 0; j < NUM_STATUS; j++) begin
            status_q[j] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CTRL; i++) begin
            if (w_accept && waddr == ADDR_WIDTH'(i)) begin
               ctrl_q[i] <= (ctrl_q[i] & ~wmask) | (wdata & wmask);
            end
         end
         // Set is OR-ed after the clear so a coincident hardware set wins.
         for (int j = 0; j < NUM_STATUS; j++) begin
            status_q[j] <= (status_q[j] & ~status_clr[j])
                           | hw_set_i[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
      assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
   end

   rf_resp_slot #(.W(1)) u_b_slot (
      .clk      (clk),
      .rst      (rst),
      .s_tvalid (wvalid),
      .s_tready (wready),
      .s_tdata  (b_resp_d),
      .m_tvalid (bvalid),
      .m_tready (bready),
      .m_tdata  (bresp)
   );

   rf_resp_slot #(.W(DATA_WIDTH + 1)) u_r_slot (
      .clk      (clk),
      .rst      (rst),
      .s_tvalid (arvalid),
      .s_tready (aready),
      .s_tdata  ({r_resp_d, r_data_d}),
      .m_tvalid (rvalid),
      .m_tready (rready),
      .m_tdata  (r_payload)
   );

   assign rresp = r_payload[DATA_WIDTH];
   assign rdata = r_payload[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_rf_bank.sv
// tb/tb_rf_bank.sv - scoreboard testbench for rf_bank
module tb_rf_bank;

   localparam int          AW  = 4;
   localparam int          DW  = 32;
   localparam int          NC  = 8;
   localparam int          NS  = 4;
   localparam logic [31:0] CRV = 32'hC0DE_0000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wvalid = 1'b0;
   logic              wready;
   logic [AW-1:0]     waddr = '0;
   logic [DW-1:0]     wdata = '0;
   logic [DW/8-1:0]   wstrb = '0;
   logic              bvalid;
   logic              bready = 1'b0;
   logic              bresp;
   logic              arvalid = 1'b0;
   logic              aready;
   logic [AW-1:0]     raddr = '0;
   logic              rvalid;
   logic              rready = 1'b0;
   logic [DW-1:0]     rdata;
   logic              rresp;
   logic [NC*DW-1:0]  ctrl_o;
   logic [NS*DW-1:0]  hw_set_i = '0;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_ctrl [NC];
   logic [31:0] m_stat [NS];
   bit          mb_valid;
   bit          mr_valid;
   logic        bq[$];
   logic [32:0] rq[$];

   logic        r_hold = 1'b0;
   logic [32:0] r_held;

   always #5 clk = ~clk;

   rf_bank #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_CTRL   (NC),
      .NUM_STATUS (NS),
      .CTRL_RESET (CRV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wvalid   (wvalid),
      .wready   (wready),
      .waddr    (waddr),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .bvalid   (bvalid),
      .bready   (bready),
      .bresp    (bresp),
      .arvalid  (arvalid),
      .aready   (aready),
      .raddr    (raddr),
      .rvalid   (rvalid),
      .rready   (rready),
      .rdata    (rdata),
      .rresp    (rresp),
      .ctrl_o   (ctrl_o),
      .hw_set_i (hw_set_i)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) m_ctrl[i] = CRV;
      for (int j = 0; j < NS; j++) m_stat[j] = '0;
      mb_valid = 0;
      mr_valid = 0;
      bq.delete();
      rq.delete();
   endtask

   // One clock of stimulus: drive after the edge, check readies, update the model.
   task automatic step(input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic br, input logic av,
                       input logic [3:0] ra, input logic rr, input logic [127:0] hs);
      logic        w_acc, a_acc;
      logic [31:0] mask;
      int          idx;
      @(posedge clk); #1;
      for (int i = 0; i < NC; i++)
         chk($sformatf("ctrl_o[%0d]", i), 64'(ctrl_o[i*DW +: DW]), 64'(m_ctrl[i]));
      wvalid = wv; waddr = wa; wdata = wd; wstrb = ws; bready = br;
      arvalid = av; raddr = ra; rready = rr; hw_set_i = hs;
      #1;
      chk("wready", 64'(wready), 64'(!mb_valid || br));
      chk("aready", 64'(aready), 64'(!mr_valid || rr));
      w_acc = wv && (!mb_valid || br);
      a_acc = av && (!mr_valid || rr);
      if (a_acc) begin
         idx = int'(ra);
         if (idx < NC)           rq.push_back({1'b0, m_ctrl[idx]});
         else if (idx < NC + NS) rq.push_back({1'b0, m_stat[idx - NC]});
         else                    rq.push_back({1'b1, 32'h0});
      end
      if (w_acc) begin
         idx = int'(wa);
         for (int b = 0; b < 4; b++) mask[b*8 +: 8] = ws[b] ? 8'hFF : 8'h00;
         if (idx < NC) begin
            m_ctrl[idx] = (m_ctrl[idx] & ~mask) | (wd & mask);
            bq.push_back(1'b0);
         end else if (idx < NC + NS) begin
`ifdef RF_BANK_W1C_EN
            m_stat[idx - NC] = m_stat[idx - NC] & ~(wd & mask);
            bq.push_back(1'b0);
`else
            bq.push_back(1'b1);
`endif
         end else begin
            bq.push_back(1'b1);
         end
      end
      for (int j = 0; j < NS; j++) m_stat[j] = m_stat[j] | hs[j*32 +: 32];
      mb_valid = w_acc ? 1'b1 : (br ? 1'b0 : mb_valid);
      mr_valid = a_acc ? 1'b1 : (rr ? 1'b0 : mr_valid);
   endtask

   // Reset with a write in flight; that write must leave no trace.
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      wvalid = 1'b1; waddr = 4'd3; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      arvalid = 1'b0; hw_set_i = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      wvalid = 1'b0; arvalid = 1'b0;
      model_reset();
      #1;
      chk("rst_wready", 64'(wready), 64'd1);
      chk("rst_aready", 64'(aready), 64'd1);
      chk("rst_bvalid", 64'(bvalid), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_bresp",  64'(bresp),  64'd0);
      chk("rst_rresp",  64'(rresp),  64'd0);
      chk("rst_rdata",  64'(rdata),  64'd0);
      chk("rst_ctrl3",  64'(ctrl_o[3*DW +: DW]), 64'(CRV));
      chk("rst_ctrl0",  64'(ctrl_o[0 +: DW]),    64'(CRV));
   endtask

   // Monitor: pops expectations on each response handshake, checks stall stability.
   always @(negedge clk) begin
      if (rst) begin
         r_hold = 1'b0;
      end else begin
         if (r_hold) begin
            chk("r_stall_valid", 64'(rvalid), 64'd1);
            chk("r_stall_data",  64'({rresp, rdata}), 64'(r_held));
         end
         if (bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
            else                chk("bresp", 64'(bresp), 64'(bq.pop_front()));
         end
         if (rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
            else                chk("rresp_rdata", 64'({rresp, rdata}), 64'(rq.pop_front()));
         end
         r_hold = rvalid && !rready;
         r_held = {rresp, rdata};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] hs;
      model_reset();
      do_reset();

      // Full and partial writes to control word 2, with read-back
      step(1, 4'd2, 32'hDEADBEEF, 4'hF, 1, 0, 4'd0, 1, '0);
      step(0, 4'd0, 32'h0, 4'h0, 1, 1, 4'd2, 1, '0);
      chk("ctrl2_full", 64'(ctrl_o[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
      step(1, 4'd2, 32'h11223344, 4'b0101, 1, 0, 4'd0, 1, '0);
      step(0, 4'd0, 32'h0, 4'h0, 1, 1, 4'd2, 1, '0);
      chk("ctrl2_partial", 64'(ctrl_o[2*DW +: DW]), 64'h0000_0000_DE22_BE44);

      // B channel stall; reads keep flowing every cycle
      step(1, 4'd1, 32'hA5A5A5A5, 4'hF, 0, 1, 4'd1, 1, '0);
      step(1, 4'd4, 32'h0F0F0F0F, 4'hF, 0, 1, 4'd1, 1, '0);
      step(1, 4'd4, 32'h0F0F0F0F, 4'hF, 0, 1, 4'd4, 1, '0);
      step(1, 4'd4, 32'h0F0F0F0F, 4'hF, 1, 1, 4'd4, 1, '0);
      step(0, 4'd0, 32'h0, 4'h0, 1, 1, 4'd4, 1, '0);

      // Status bit 3 of status 0, software clear, and clear colliding with set
      hs = '0; hs[3] = 1'b1;
      step(0, 4'd0, 32'h0, 4'h0, 1, 0, 4'd0, 1, hs);
      step(0, 4'd0, 32'h0, 4'h0, 1, 1, 4'd8, 1, '0);
      step(1, 4'd8, 32'h8, 4'hF, 1, 0, 4'd0, 1, '0);
      step(0, 4'd0, 32'h0, 4'h0, 1, 1, 4'd8, 1, '0);
      step(1, 4'd8, 32'h8, 4'hF, 1, 0, 4'd0, 1, hs);
      step(0, 4'd0, 32'h0, 4'h0, 1, 1, 4'd8, 1, '0);

      // Unmapped address on both channels
      step(0, 4'd0, 32'h0, 4'h0, 1, 1, 4'd15, 1, '0);
      step(1, 4'd15, 32'hFFFFFFFF, 4'hF, 1, 0, 4'd0, 1, '0);
      step(0, 4'd0, 32'h0, 4'h0, 1, 0, 4'd0, 1, '0);

      // R channel stalled, then reset while the response is pending
      step(0, 4'd0, 32'h0, 4'h0, 1, 1, 4'd2, 0, '0);
      step(0, 4'd0, 32'h0, 4'h0, 1, 1, 4'd1, 0, '0);
      step(0, 4'd0, 32'h0, 4'h0, 1, 0, 4'd0, 0, '0);
      do_reset();

      // Randomised traffic
      for (int n = 0; n < 2000; n++) begin
         hs = '0;
         if ($urandom_range(0, 3) == 0) hs[$urandom_range(0, 127)] = 1'b1;
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 9) < 7), hs);
      end

      // Drain outstanding responses
      for (int n = 0; n < 4; n++) step(0, 4'd0, 32'h0, 4'h0, 1, 0, 4'd0, 1, '0);
      chk("bq_drained", 64'(bq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_bank.md
# rf_bank

Parametrised PS-side register bank, the successor to the single-cycle register node. It gives the processing system a control/status register file with proper valid/ready handshakes on both the write and read paths, byte strobes, registered reads, and error responses. The bank is split into two regions:
- Control registers, which software writes and the datapath consumes.
- Status registers, which hardware sets and software reads and clears.

It sits between the PS slave interface and the accelerator datapath.

## Interface
Parameters:
- ADDR_WIDTH, 4: word address width; the bank has 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: register width; must be a multiple of 8.
- NUM_CTRL, 8: control registers at word addresses 0..NUM_CTRL-1.
- NUM_STATUS, 4: status registers at word addresses NUM_CTRL..NUM_CTRL+NUM_STATUS-1. Must satisfy NUM_CTRL+NUM_STATUS <= 2**ADDR_WIDTH.
- CTRL_RESET, '0: reset value of every control register.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- wvalid, in, 1: write request valid.
- wready, out, 1: write request accepted when wvalid && wready.
- waddr, in, ADDR_WIDTH: word address of the write.
- wdata, in, DATA_WIDTH: write data.
- wstrb, in, DATA_WIDTH/8: byte enables.
- bvalid, out, 1: write response valid.
- bready, in, 1: write response consumed.
- bresp, out, 1: 0 = OK, 1 = ERR.
- arvalid, in, 1: read request valid.
- aready, out, 1: read request accepted when arvalid && aready.
- raddr, in, ADDR_WIDTH: word address of the read.
- rvalid, out, 1: read data valid.
- rready, in, 1: read data consumed.
- rdata, out, DATA_WIDTH: read data.
- rresp, out, 1: 0 = OK, 1 = ERR.
- ctrl_o, out, NUM_CTRL*DATA_WIDTH: all control registers, flattened; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- hw_set_i, in, NUM_STATUS*DATA_WIDTH: per-bit set pulses for the status registers, same packing as ctrl_o.

## Operation
Write channel:
- One outstanding write. wready = !bvalid || bready.
- On acceptance, the write commits and the response is registered together, on the same edge.
- Control address: each byte with wstrb=1 is updated; bresp=OK.
- Status address: see Configuration.
- Unmapped address (>= NUM_CTRL+NUM_STATUS): no state changes; bresp=ERR.

Read channel:
- One outstanding read. aready = !rvalid || rready.
- On acceptance, rdata and rresp are registered from the current register contents.
- Unmapped address: rdata=0, rresp=ERR.

Status registers:
- Every bit is sticky: status[b] <= status[b] | hw_set_i[b], every cycle.
- If a software clear and a hardware set hit the same bit in the same cycle, the set wins and the bit reads 1.

## Timing
- Reset values: wready=1, aready=1, bvalid=0, bresp=0, rvalid=0, rdata=0, rresp=0, control registers=CTRL_RESET, status registers=0.
- Write latency: a write accepted in cycle N is visible on ctrl_o, and bvalid is 1, in cycle N+1.
- Read latency: a read accepted in cycle N gives rvalid=1 with data in cycle N+1. rdata, rresp and rvalid stay stable while rvalid && !rready.
- Back-to-back throughput: with bready=1 or rready=1 held high, one transaction per cycle per channel.
- Same-cycle read and write to the same address: the read returns the pre-write value.
- A hw_set_i pulse in cycle N is readable by a read accepted in cycle N+1 or later.
- Reset asserted mid-transaction: the pending response is dropped (bvalid=0, rvalid=0 on the next cycle) and the interrupted write has no effect.
- The write and read channels are fully independent; neither ever stalls the other.

## Configuration
Macro RF_BANK_W1C_EN selects how software writes to status registers are handled.
- Defined: write-1-to-clear. Each bit where wdata=1 and the corresponding wstrb byte is 1 is cleared; bresp=OK.
- Undefined: status registers are read-only. A write changes nothing and returns bresp=ERR.

## Structure
Package rf_bank_pkg holds:
- Typedef resp_t, 1 bit, with values RESP_OK=0 and RESP_ERR=1.
- Function strb_mask(wstrb), which expands byte enables into a bit mask.
- Function addr_is_ctrl / addr_is_status, which classify an address as control or status.

Sub-module rf_resp_slot: a one-entry valid/ready output register, instantiated once for the B channel and once for the R channel. It owns the valid/ready logic and holds the payload stable under stall.

## Test plan
- Reset, then write waddr=2, wdata=0xDEADBEEF, wstrb=4'hF -> bvalid next cycle, bresp=0. ctrl_o word 2 = 0xDEADBEEF. A read of 2 returns 0xDEADBEEF with rvalid one cycle after acceptance.
- Partial write to waddr=2, wdata=0x11223344, wstrb=4'b0101 -> word 2 = 0xDE22BE44.
- Hold bready=0 after a write -> wready=0. A second write stalls until bready=1, then is accepted that same cycle. Read throughput is unaffected while the write channel is stalled.
- hw_set_i sets bit 3 of status 0 (address NUM_CTRL) -> a read returns 0x8.
  - With RF_BANK_W1C_EN: write 0x8 -> the read returns 0; write 0x8 in the same cycle as a set of bit 3 -> the read returns 0x8.
  - Without RF_BANK_W1C_EN: the write returns bresp=1 and the value is unchanged.
- Read raddr=15 with defaults -> rdata=0, rresp=1. Write waddr=15 -> bresp=1 and no register changes.
- Assert rst while rvalid=1 and rready=0 -> rvalid=0 next cycle and all control registers = CTRL_RESET.
